// File: rtl/mem_cycle_sequencer_pkg.sv
// rtl/mem_cycle_sequencer_pkg.sv - cycle kinds, sequencer states and idle strobe levels
package opcodes;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    LOAD    = 2'd1,
    STORE   = 2'd2,
    ILLEGAL = 2'd3
  } mem_cycle_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    WAIT = 3'd2,
    CAPT = 3'd3,
    HOLD = 3'd4
  } seq_state_t;

  // Pad strobes are active low, so their idle level is 1.
  localparam logic IDLE_NME = 1'b1;
  localparam logic IDLE_NOE = 1'b1;
  localparam logic IDLE_NWE = 1'b1;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mem_cycle_sequencer_if.sv
// rtl/mem_cycle_sequencer_if.sv - Req/Done handshake and pad strobes; MEM_READY_EN adds nWait/BusErr
interface mem_cycle_sequencer_if;
  logic               Req;
  opcodes::mem_cycle_t Kind;
  logic               Busy;
  logic               Done;
  logic               PcEn;
  logic               AddrEn;
  logic               ALE;
  logic               nME;
  logic               nOE;
  logic               nWE;
  logic               ENB;
  logic               MemEn;
  logic               IrWe;
  logic               DataWe;
  logic               Illegal;
`ifdef MEM_READY_EN
  logic               nWait;
  logic               BusErr;
`endif

  modport master (
`ifdef MEM_READY_EN
    output nWait,
    input  BusErr,
`endif
    output Req, Kind,
    input  Busy, Done, PcEn, AddrEn, ALE, nME, nOE, nWE, ENB, MemEn, IrWe, DataWe, Illegal
  );

  modport slave (
`ifdef MEM_READY_EN
    input  nWait,
    output BusErr,
`endif
    input  Req, Kind,
    output Busy, Done, PcEn, AddrEn, ALE, nME, nOE, nWE, ENB, MemEn, IrWe, DataWe, Illegal
  );
endinterface

// File: rtl/mem_cycle_sequencer_phase_counter.sv
// rtl/mem_cycle_sequencer_phase_counter.sv - loadable down-counter, expires at 1 and saturates there
module phase_counter #(
  parameter int WIDTH = 2
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic             Expire
);
  logic [WIDTH-1:0] count;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
    end else if (Load) begin
      count <= LoadValue;
    end else if (count > WIDTH'(1)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign Expire = (count == WIDTH'(1));
endmodule

// File: rtl/mem_cycle_sequencer.sv
// rtl/mem_cycle_sequencer.sv - external memory bus-cycle engine (FETCH/LOAD/STORE)
// MEM_READY_EN adds nWait stretching of WAIT with a WAIT_TIMEOUT bus-error escape.
module mem_cycle_sequencer
  import opcodes::*;
#(
  parameter int ALE_CYCLES   = 1,
  parameter int WAIT_CYCLES  = 2,
  parameter int HOLD_CYCLES  = 1
`ifdef MEM_READY_EN
  ,
  parameter int WAIT_TIMEOUT = 64
`endif
) (
  input  logic                  Clock,
  input  logic                  nReset,
  mem_cycle_sequencer_if.slave  bus
);
  localparam int CW = $clog2(maxOf3(ALE_CYCLES, WAIT_CYCLES, HOLD_CYCLES) + 1);

  seq_state_t      state, nextState;
  mem_cycle_t      kindQ;
  logic            illegalQ;
  logic            accept, acceptLegal;
  logic            load, expire, waitDone;
  logic [CW-1:0]   loadValue;

  // With no HOLD phase, CAPT may chain straight into the next cycle.
  assign accept      = bus.Req && ((state == IDLE) || ((state == CAPT) && (HOLD_CYCLES == 0)));
  assign acceptLegal = accept && (bus.Kind != ILLEGAL);

`ifdef MEM_READY_EN
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);
  logic [TW-1:0] waitTicks;
  logic          timeoutHit, timedOutQ;

  assign timeoutHit = (state == WAIT) && (waitTicks == TW'(WAIT_TIMEOUT - 1)) &&
                      !(expire && bus.nWait);
  assign waitDone   = (expire && bus.nWait) || timeoutHit;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      waitTicks <= '0;
      timedOutQ <= 1'b0;
    end else begin
      waitTicks <= (state == WAIT) ? waitTicks + TW'(1) : '0;
      timedOutQ <= timeoutHit;
    end
  end
`else
  assign waitDone = expire;
`endif

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= IDLE;
      kindQ    <= FETCH;
      illegalQ <= 1'b0;
    end else begin
      state    <= nextState;
      illegalQ <= accept && (bus.Kind == ILLEGAL);
      if (acceptLegal) kindQ <= bus.Kind;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (acceptLegal) nextState = ADDR;
      ADDR: if (expire) nextState = (WAIT_CYCLES != 0) ? WAIT : CAPT;
      WAIT: if (waitDone) nextState = CAPT;
      CAPT: begin
        if (acceptLegal)           nextState = ADDR;
        else if (HOLD_CYCLES != 0) nextState = HOLD;
        else                       nextState = IDLE;
      end
      HOLD:    if (expire) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign load = (nextState != state);

  always_comb begin
    case (nextState)
      ADDR:    loadValue = CW'(ALE_CYCLES);
      WAIT:    loadValue = CW'(WAIT_CYCLES);
      HOLD:    loadValue = CW'(HOLD_CYCLES);
      default: loadValue = '0;
    endcase
  end

  phase_counter #(.WIDTH(CW)) uPhase (
    .Clock     (Clock),
    .nReset    (nReset),
    .Load      (load),
    .LoadValue (loadValue),
    .Expire    (expire)
  );

  always_comb begin
    bus.Busy    = (state != IDLE);
    bus.Done    = 1'b0;
    bus.PcEn    = 1'b0;
    bus.AddrEn  = 1'b0;
    bus.ALE     = 1'b0;
    bus.nME     = IDLE_NME;
    bus.nOE     = IDLE_NOE;
    bus.nWE     = IDLE_NWE;
    bus.ENB     = 1'b0;
    bus.MemEn   = 1'b0;
    bus.IrWe    = 1'b0;
    bus.DataWe  = 1'b0;
    bus.Illegal = illegalQ;
`ifdef MEM_READY_EN
    bus.BusErr  = 1'b0;
`endif
    case (state)
      ADDR: begin
        bus.ALE = 1'b1;
        bus.nME = 1'b0;
        if (kindQ == FETCH) bus.PcEn = 1'b1;
        else                bus.AddrEn = 1'b1;
        if (kindQ == STORE) bus.MemEn = 1'b1;
      end
      WAIT: begin
        bus.nME = 1'b0;
        if (kindQ == STORE) begin
          bus.nWE   = 1'b0;
          bus.MemEn = 1'b1;
        end else begin
          bus.nOE = 1'b0;
          bus.ENB = 1'b1;
        end
      end
      CAPT: begin
        bus.nME   = 1'b0;
        bus.Done  = 1'b1;
        bus.MemEn = 1'b1;
        if (kindQ == STORE) begin
          bus.nWE = 1'b0;
        end else begin
          bus.nOE = 1'b0;
          bus.ENB = 1'b1;
`ifdef MEM_READY_EN
          bus.BusErr = timedOutQ;
          bus.IrWe   = (kindQ == FETCH) && !timedOutQ;
          bus.DataWe = (kindQ == LOAD) && !timedOutQ;
`else
          bus.IrWe   = (kindQ == FETCH);
          bus.DataWe = (kindQ == LOAD);
`endif
        end
      end
      HOLD:    bus.nME = 1'b0;
      default: ;
    endcase
  end

  assert property (@(posedge Clock) disable iff (!nReset) !(!bus.nOE && !bus.nWE));
endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// tb/tb_mem_cycle_sequencer.sv - directed bench: defaults, WAIT_CYCLES=3 and HOLD_CYCLES=0 instances; MEM_READY_EN ties nWait high
module tb_mem_cycle_sequencer;
  import opcodes::*;

  logic Clock;
  logic nReset;
  int   checks;
  int   failures;

  mem_cycle_sequencer_if if0 ();
  mem_cycle_sequencer_if if1 ();
  mem_cycle_sequencer_if if2 ();

  mem_cycle_sequencer dut0 (.Clock(Clock), .nReset(nReset), .bus(if0));
  mem_cycle_sequencer #(.WAIT_CYCLES(3)) dut1 (.Clock(Clock), .nReset(nReset), .bus(if1));
  mem_cycle_sequencer #(.HOLD_CYCLES(0)) dut2 (.Clock(Clock), .nReset(nReset), .bus(if2));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // {Busy,Done,PcEn,AddrEn,ALE,nME,nOE,nWE,ENB,MemEn,IrWe,DataWe,Illegal}
  localparam logic [12:0] V_IDLE       = 13'b0000011100000;
  localparam logic [12:0] V_ADDR_FETCH = 13'b1010101100000;
  localparam logic [12:0] V_ADDR_LOAD  = 13'b1001101100000;
  localparam logic [12:0] V_ADDR_STORE = 13'b1001101101000;
  localparam logic [12:0] V_WAIT_READ  = 13'b1000000110000;
  localparam logic [12:0] V_WAIT_STORE = 13'b1000001001000;
  localparam logic [12:0] V_CAPT_FETCH = 13'b1100000111100;
  localparam logic [12:0] V_CAPT_LOAD  = 13'b1100000111010;
  localparam logic [12:0] V_CAPT_STORE = 13'b1100001001000;
  localparam logic [12:0] V_HOLD       = 13'b1000001100000;
  localparam logic [12:0] V_ILLEGAL    = 13'b0000011100001;

  function automatic logic [12:0] outs(input int d);
    case (d)
      0: return {if0.Busy, if0.Done, if0.PcEn, if0.AddrEn, if0.ALE, if0.nME, if0.nOE,
                 if0.nWE, if0.ENB, if0.MemEn, if0.IrWe, if0.DataWe, if0.Illegal};
      1: return {if1.Busy, if1.Done, if1.PcEn, if1.AddrEn, if1.ALE, if1.nME, if1.nOE,
                 if1.nWE, if1.ENB, if1.MemEn, if1.IrWe, if1.DataWe, if1.Illegal};
      default: return {if2.Busy, if2.Done, if2.PcEn, if2.AddrEn, if2.ALE, if2.nME, if2.nOE,
                       if2.nWE, if2.ENB, if2.MemEn, if2.IrWe, if2.DataWe, if2.Illegal};
    endcase
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    for (int d = 0; d < 3; d++) begin
      got = outs(d);
      checks++;
      if (got !== V_IDLE) begin
        failures++;
        $display("FAIL reset_state dut%0d got %b want %b", d, got, V_IDLE);
      end
    end
  endtask

  task automatic test_fetch();
    logic [12:0] exp [1:6];
    logic [12:0] got;
    exp[1] = V_ADDR_FETCH; exp[2] = V_WAIT_READ; exp[3] = V_WAIT_READ;
    exp[4] = V_CAPT_FETCH; exp[5] = V_HOLD;      exp[6] = V_IDLE;
    if0.Kind = FETCH;
    if0.Req  = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      tick();
      if (n == 1) if0.Req = 1'b0;
      got = outs(0);
      checks++;
      if (got !== exp[n]) begin
        failures++;
        $display("FAIL fetch cycle %0d got %b want %b", n, got, exp[n]);
      end
    end
  endtask

  task automatic test_store_wait3();
    logic [12:0] exp [1:7];
    logic [12:0] got;
    exp[1] = V_ADDR_STORE; exp[2] = V_WAIT_STORE; exp[3] = V_WAIT_STORE;
    exp[4] = V_WAIT_STORE; exp[5] = V_CAPT_STORE; exp[6] = V_HOLD; exp[7] = V_IDLE;
    if1.Kind = STORE;
    if1.Req  = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      tick();
      if (n == 1) if1.Req = 1'b0;
      got = outs(1);
      checks++;
      if (got !== exp[n]) begin
        failures++;
        $display("FAIL store_wait3 cycle %0d got %b want %b", n, got, exp[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp [1:9];
    logic [12:0] got;
    exp[1] = V_ADDR_FETCH; exp[2] = V_WAIT_READ; exp[3] = V_WAIT_READ;
    exp[4] = V_CAPT_FETCH; exp[5] = V_ADDR_LOAD; exp[6] = V_WAIT_READ;
    exp[7] = V_WAIT_READ;  exp[8] = V_CAPT_LOAD; exp[9] = V_IDLE;
    if2.Kind = FETCH;
    if2.Req  = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      tick();
      if (n == 1) if2.Kind = LOAD;
      if (n == 5) if2.Req = 1'b0;
      got = outs(2);
      checks++;
      if (got !== exp[n]) begin
        failures++;
        $display("FAIL back_to_back cycle %0d got %b want %b", n, got, exp[n]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [12:0] got;
    if0.Kind = ILLEGAL;
    if0.Req  = 1'b1;
    tick();
    if0.Req = 1'b0;
    got = outs(0);
    checks++;
    if (got !== V_ILLEGAL) begin
      failures++;
      $display("FAIL illegal_pulse got %b want %b", got, V_ILLEGAL);
    end
    tick();
    got = outs(0);
    checks++;
    if (got !== V_IDLE) begin
      failures++;
      $display("FAIL illegal_clear got %b want %b", got, V_IDLE);
    end
    if0.Kind = FETCH;
  endtask

  task automatic test_reset_mid_cycle();
    logic [12:0] got;
    if0.Kind = LOAD;
    if0.Req  = 1'b1;
    tick();
    if0.Req = 1'b0;
    got = outs(0);
    checks++;
    if (got !== V_ADDR_LOAD) begin
      failures++;
      $display("FAIL rst_pre_addr got %b want %b", got, V_ADDR_LOAD);
    end
    tick();
    got = outs(0);
    checks++;
    if (got !== V_WAIT_READ) begin
      failures++;
      $display("FAIL rst_pre_wait got %b want %b", got, V_WAIT_READ);
    end
    #1 nReset = 1'b0;
    #1;
    got = outs(0);
    checks++;
    if (got !== V_IDLE) begin
      failures++;
      $display("FAIL rst_async got %b want %b", got, V_IDLE);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      got = outs(0);
      checks++;
      if (got !== V_IDLE) begin
        failures++;
        $display("FAIL rst_held cycle %0d got %b want %b", n, got, V_IDLE);
      end
    end
    nReset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      got = outs(0);
      checks++;
      if (got !== V_IDLE) begin
        failures++;
        $display("FAIL rst_release cycle %0d got %b want %b", n, got, V_IDLE);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nReset   = 1'b0;
    if0.Req = 1'b0; if0.Kind = FETCH;
    if1.Req = 1'b0; if1.Kind = FETCH;
    if2.Req = 1'b0; if2.Kind = FETCH;
`ifdef MEM_READY_EN
    if0.nWait = 1'b1;
    if1.nWait = 1'b1;
    if2.nWait = 1'b1;
`endif
    tick();
    tick();
    test_reset();
    nReset = 1'b1;
    tick();
    test_reset();
    test_fetch();
    test_store_wait3();
    test_back_to_back();
    test_illegal();
    test_reset_mid_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_cycle_sequencer.md
Name: mem_cycle_sequencer

Overview:
- Parametrised bus-cycle sequencer for the external memory pads. It replaces the fixed five-step fetch sub-FSM with a generic engine.
- Runs instruction-fetch, data-load and data-store cycles with configurable address-latch, wait and hold phase lengths.
- Driven by the main control FSM through a Req/Done handshake; generates all pad strobes and the internal enables (PcEn, IrWe, DataWe).

Parameters:
- ALE_CYCLES, 1, cycles ALE held high in the address phase (1..4).
- WAIT_CYCLES, 2, access cycles between address phase and data capture (0..15).
- HOLD_CYCLES, 1, cycles after capture with nME still asserted, for bus turnaround (0..3).

Ports:
- Clock  in  1  system clock, all state updates on rising edge.
- nReset  in  1  asynchronous active-low reset.
- Req  in  1  level request; sampled only in IDLE.
- Kind  in  2  cycle type, opcodes::mem_cycle_t: FETCH=0, LOAD=1, STORE=2; 3 is illegal.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse on the capture/commit cycle.
- PcEn  out  1  PC drives SysBus (FETCH address phase).
- AddrEn  out  1  address register drives SysBus (LOAD/STORE address phase).
- ALE  out  1  address latch enable.
- nME  out  1  memory enable, active low.
- nOE  out  1  output enable, active low (reads).
- nWE  out  1  write enable, active low (STORE).
- ENB  out  1  pad direction: 1 = pad to core.
- MemEn  out  1  pad driver enable.
- IrWe  out  1  IR write strobe (FETCH capture).
- DataWe  out  1  load-data register write strobe (LOAD capture).
- Illegal  out  1  one-cycle pulse when Kind==3 is accepted.

Behaviour:
- Reset (async, immediate, including mid-cycle):
  - State IDLE; counters 0; latched Kind = FETCH.
  - Outputs: nME=nOE=nWE=1; all other outputs 0.
- State machine IDLE -> ADDR -> WAIT -> CAPT -> HOLD -> IDLE:
  - WAIT is skipped when WAIT_CYCLES=0; HOLD is skipped when HOLD_CYCLES=0.
- IDLE:
  - Req=1 with legal Kind: latch Kind, go to ADDR next edge.
  - Kind==3: pulse Illegal, stay IDLE.
- ADDR, ALE_CYCLES cycles:
  - ALE=1, nME=0.
  - PcEn=1 for FETCH, AddrEn=1 otherwise.
  - STORE also asserts MemEn=1, ENB=0.
- WAIT, WAIT_CYCLES cycles:
  - nME=0.
  - Reads: nOE=0, ENB=1.
  - STORE: nWE=0, MemEn=1, ENB=0, AddrEn=0.
- CAPT, exactly 1 cycle:
  - nME=0, Done=1.
  - Reads: nOE=0, ENB=1, MemEn=1, plus IrWe (FETCH) or DataWe (LOAD).
  - STORE: nWE=0, MemEn=1.
- HOLD, HOLD_CYCLES cycles: nME=0 only; nOE=nWE=1, MemEn=0.
- Latency from accepting edge to Done: ALE_CYCLES + WAIT_CYCLES + 1 cycles. Defaults: 4.
- Back-to-back:
  - With HOLD_CYCLES=0 and Req still high at CAPT, CAPT moves directly to ADDR for the new Kind. There is no idle bubble.
  - Otherwise Req is resampled in IDLE.
- Req and Kind changes while Busy=1 are ignored; Kind is latched.
- Phase counter: a single down-counter, width $clog2(max(ALE_CYCLES, WAIT_CYCLES, HOLD_CYCLES)+1), reloaded on each phase entry. A phase exits when the count reaches 1.
- nOE and nWE are never low in the same cycle. Assert this in simulation.

Optional Feature:
- MEM_READY_EN defined:
  - Adds input nWait (1 bit, active low, synchronised externally).
  - After the WAIT count expires, the block stays in WAIT while nWait=0 and holds strobes at WAIT values.
  - Also adds parameter WAIT_TIMEOUT (default 64). Exceeding it forces CAPT with Done=1 and a one-cycle BusErr output pulse; IrWe and DataWe are suppressed in that cycle.
- Undefined: no nWait or BusErr ports; WAIT length is fixed.

Decomposition:
- Package opcodes:
  - mem_cycle_t enum (FETCH, LOAD, STORE, ILLEGAL).
  - seq_state_t enum (IDLE, ADDR, WAIT, CAPT, HOLD).
  - Constants for the idle strobe values.
- Sub-module phase_counter: loadable down-counter with load value, load and expire outputs.
- Output decode is one always_comb on (state, latched Kind).

Test Plan:
- FETCH, defaults, Req at edge 0 -> ALE high edge 1; nOE low edges 2-4; IrWe and Done at edge 4; nME released edge 6; DataWe never high.
- STORE with WAIT_CYCLES=3 -> nWE low for exactly 4 cycles; MemEn=1 and ENB=0 from ADDR through CAPT; nOE stays 1.
- HOLD_CYCLES=0 with Req held and Kind FETCH then LOAD -> Done pulses 4 cycles apart; ALE re-asserts the cycle after CAPT; DataWe on the second Done.
- nReset low during WAIT of a LOAD -> all outputs return to reset values within the same cycle with no clock; DataWe never pulses; IDLE on release.
- Kind=3 with Req=1 -> Illegal=1 for 1 cycle; Busy stays 0; all strobes idle.
- MEM_READY_EN with nWait held low 10 cycles -> CAPT 10 cycles late. With nWait stuck low -> BusErr and Done together 64 cycles after WAIT entry; IrWe stays 0.
